// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory port plus the decode/execute handshake.
// The master modport is the fetch side, the slave modport is its environment.
interface fetch_if #(
    parameter int ADDR_W = 14
);
    logic              interlock;
    logic              decode_stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [63:0]       imem_rdata;
    logic [63:0]       inst;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        input  interlock, decode_stall, redirect, redirect_pc, imem_rdata,
        output imem_en, imem_addr, inst, inst_pc
    );

    modport slave (
        output interlock, decode_stall, redirect, redirect_pc, imem_rdata,
        input  imem_en, imem_addr, inst, inst_pc
    );
endinterface

// File: rtl/fetch.sv
// Instruction fetch for the 2-wide core: owns the PC, drives a 1-cycle imem,
// and hands 64-bit bundles to decode through a skid buffer and output register.
module fetch #(
    parameter int                ADDR_W   = 14,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic  clk,
    input  logic  rstn,
    fetch_if.master bus
);
    localparam logic [63:0] NOP = 64'hE000_0000_E000_0000;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] rd_pc_q, rd_pc_d;
    logic [63:0]       skid_q, skid_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic              skid_valid_q, skid_valid_d;
    logic [63:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

    logic advance;
    logic req;

    assign advance = ~bus.interlock & ~bus.decode_stall;

    // Only request when the returning data is guaranteed a slot next cycle.
    assign req = ~bus.redirect &
                 (advance ? ~(skid_valid_q & rd_valid_q)
                          : (~skid_valid_q & ~rd_valid_q));

    assign bus.imem_en   = req;
    assign bus.imem_addr = pc_q;
    assign bus.inst      = inst_q;
    assign bus.inst_pc   = inst_pc_q;

    always_comb begin
        pc_d         = pc_q;
        rd_valid_d   = 1'b0;
        rd_pc_d      = rd_pc_q;
        skid_d       = skid_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;

        if (bus.redirect) begin
            pc_d         = bus.redirect_pc;
            skid_valid_d = 1'b0;
            inst_d       = NOP;
            inst_pc_d    = '0;
        end else begin
            if (req) begin
                pc_d       = pc_q + ADDR_W'(1);
                rd_valid_d = 1'b1;
                rd_pc_d    = pc_q;
            end

            if (advance) begin
                // Oldest bundle first: skid, then the read just returning.
                if (skid_valid_q) begin
                    inst_d    = skid_q;
                    inst_pc_d = skid_pc_q;
                    if (rd_valid_q) begin
                        skid_d       = bus.imem_rdata;
                        skid_pc_d    = rd_pc_q;
                        skid_valid_d = 1'b1;
                    end else begin
                        skid_valid_d = 1'b0;
                    end
                end else if (rd_valid_q) begin
                    inst_d       = bus.imem_rdata;
                    inst_pc_d    = rd_pc_q;
                    skid_valid_d = 1'b0;
                end else begin
                    inst_d       = NOP;
                    inst_pc_d    = '0;
                    skid_valid_d = 1'b0;
                end
            end else if (rd_valid_q) begin
                skid_d       = bus.imem_rdata;
                skid_pc_d    = rd_pc_q;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q         <= RESET_PC;
            rd_valid_q   <= 1'b0;
            rd_pc_q      <= '0;
            skid_q       <= '0;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            inst_q       <= NOP;
            inst_pc_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            rd_valid_q   <= rd_valid_d;
            rd_pc_q      <= rd_pc_d;
            skid_q       <= skid_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end
endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: stimulus queues expected bundle PCs, a negedge
// monitor pops them whenever decode consumes a non-NOP bundle.
module tb_fetch;
    localparam int          ADDR_W = 14;
    localparam logic [63:0] NOP    = 64'hE000_0000_E000_0000;

    logic clk;
    logic rstn;

    fetch_if #(.ADDR_W(ADDR_W)) if0 ();
    fetch_if #(.ADDR_W(ADDR_W)) ifw ();

    fetch #(.ADDR_W(ADDR_W), .RESET_PC(14'h0000)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if0)
    );

    fetch #(.ADDR_W(ADDR_W), .RESET_PC(14'h3FFE)) dut_wrap (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifw)
    );

    int                n_checks = 0;
    int                n_pass   = 0;
    int                cyc      = 0;
    bit                mon_en   = 1'b0;
    logic [ADDR_W-1:0] exp_q[$];

    function automatic logic [63:0] bundle_of(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = {18'd0, a};
        return {w, ~w};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memories with one-cycle latency.
    always @(posedge clk) begin
        if (if0.imem_en) if0.imem_rdata <= bundle_of(if0.imem_addr);
        if (ifw.imem_en) ifw.imem_rdata <= bundle_of(ifw.imem_addr);
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s (cycle %0d): got %h, expected %h",
                      name, cyc, actual, expected);
    endtask

    task automatic applyStimulus(input logic il, input logic ds,
                                 input logic rd, input logic [ADDR_W-1:0] rpc);
        @(posedge clk);
        #1;
        cyc++;
        if0.interlock    = il;
        if0.decode_stall = ds;
        if0.redirect     = rd;
        if0.redirect_pc  = rpc;
        #1;
    endtask

    task automatic push_range(input logic [ADDR_W-1:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + ADDR_W'(i));
    endtask

    // Decode consumes inst on every advance cycle; NOP bundles carry nothing.
    always @(negedge clk) begin
        logic [ADDR_W-1:0] p;
        if (mon_en && rstn && !if0.interlock && !if0.decode_stall && if0.inst !== NOP) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL unexpected_bundle (cycle %0d): got pc %h inst %h, expected none",
                         cyc, if0.inst_pc, if0.inst);
            end else begin
                p = exp_q.pop_front();
                if ({if0.inst_pc, if0.inst} === {p, bundle_of(p)}) n_pass++;
                else $display("[TB] FAIL stream_order (cycle %0d): got pc %h inst %h, expected pc %h inst %h",
                              cyc, if0.inst_pc, if0.inst, p, bundle_of(p));
            end
        end
    end

    initial begin
        rstn = 1'b1;
        if0.interlock = 1'b0; if0.decode_stall = 1'b0;
        if0.redirect  = 1'b0; if0.redirect_pc  = '0;
        ifw.interlock = 1'b0; ifw.decode_stall = 1'b0;
        ifw.redirect  = 1'b0; ifw.redirect_pc  = '0;
        #3 rstn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("reset_inst",     if0.inst, NOP);
        checkOutput("reset_inst_pc",  64'(if0.inst_pc), 64'h0);
        checkOutput("reset_addr",     64'(if0.imem_addr), 64'h0);
        checkOutput("reset_wrap_addr", 64'(ifw.imem_addr), 64'h3FFE);

        // Cold start
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        cyc    = 1;
        mon_en = 1'b1;
        push_range(14'h0, 10);
        #1;
        checkOutput("c1_inst",    if0.inst, NOP);
        checkOutput("c1_imem_en", 64'(if0.imem_en), 64'h1);
        checkOutput("c1_addr",    64'(if0.imem_addr), 64'h0);
        applyStimulus(0, 0, 0, '0);
        checkOutput("c2_inst",    if0.inst, NOP);
        applyStimulus(0, 0, 0, '0);
        checkOutput("c3_inst_pc", 64'(if0.inst_pc), 64'h0);
        checkOutput("c3_inst",    if0.inst, bundle_of(14'h0));
        checkOutput("wrap_c3",    64'(ifw.inst_pc), 64'h3FFE);
        applyStimulus(0, 0, 0, '0);
        checkOutput("c4_inst_pc", 64'(if0.inst_pc), 64'h1);
        checkOutput("wrap_c4",    64'(ifw.inst_pc), 64'h3FFF);
        applyStimulus(0, 0, 0, '0);
        checkOutput("wrap_c5",    64'(ifw.inst_pc), 64'h0000);
        checkOutput("wrap_c5_inst", ifw.inst, bundle_of(14'h0000));
        applyStimulus(0, 0, 0, '0);
        checkOutput("wrap_c6",    64'(ifw.inst_pc), 64'h0001);
        applyStimulus(0, 0, 0, '0);

        // Three-cycle decode_stall while inst holds bundle 5
        applyStimulus(0, 1, 0, '0);
        checkOutput("stall_c8_inst_pc", 64'(if0.inst_pc), 64'h5);
        applyStimulus(0, 1, 0, '0);
        checkOutput("stall_c9_imem_en", 64'(if0.imem_en), 64'h0);
        checkOutput("stall_c9_inst_pc", 64'(if0.inst_pc), 64'h5);
        applyStimulus(0, 1, 0, '0);
        checkOutput("stall_c10_imem_en", 64'(if0.imem_en), 64'h0);
        applyStimulus(0, 0, 0, '0);
        checkOutput("release_c11_inst_pc", 64'(if0.inst_pc), 64'h5);
        applyStimulus(0, 0, 0, '0);
        checkOutput("release_c12_inst_pc", 64'(if0.inst_pc), 64'h6);
        applyStimulus(0, 0, 0, '0);
        applyStimulus(0, 0, 0, '0);

        // Redirect to 0x100 while inst holds bundle 9
        applyStimulus(0, 0, 1, 14'h100);
        checkOutput("redir_c15_inst_pc", 64'(if0.inst_pc), 64'h9);
        applyStimulus(0, 0, 0, '0);
        exp_q.delete();
        push_range(14'h100, 4);
        checkOutput("redir_c16_inst",    if0.inst, NOP);
        checkOutput("redir_c16_inst_pc", 64'(if0.inst_pc), 64'h0);
        checkOutput("redir_c16_addr",    64'(if0.imem_addr), 64'h100);
        checkOutput("redir_c16_imem_en", 64'(if0.imem_en), 64'h1);
        applyStimulus(0, 0, 0, '0);
        checkOutput("redir_c17_inst",    if0.inst, NOP);
        applyStimulus(0, 0, 0, '0);
        checkOutput("redir_c18_inst_pc", 64'(if0.inst_pc), 64'h100);
        applyStimulus(0, 0, 0, '0);

        // Redirect to 0x200 while interlocked with the skid buffer full
        applyStimulus(1, 0, 0, '0);
        applyStimulus(1, 0, 1, 14'h200);
        checkOutput("sredir_c21_inst_pc", 64'(if0.inst_pc), 64'h102);
        applyStimulus(1, 0, 0, '0);
        exp_q.delete();
        push_range(14'h200, 4);
        checkOutput("sredir_c22_inst",    if0.inst, NOP);
        checkOutput("sredir_c22_imem_en", 64'(if0.imem_en), 64'h1);
        checkOutput("sredir_c22_addr",    64'(if0.imem_addr), 64'h200);
        applyStimulus(1, 0, 0, '0);
        checkOutput("sredir_c23_imem_en", 64'(if0.imem_en), 64'h0);
        checkOutput("sredir_c23_inst",    if0.inst, NOP);
        applyStimulus(1, 0, 0, '0);
        checkOutput("sredir_c24_inst",    if0.inst, NOP);
        applyStimulus(0, 0, 0, '0);
        checkOutput("sredir_c25_inst",    if0.inst, NOP);
        applyStimulus(0, 0, 0, '0);
        checkOutput("sredir_c26_inst_pc", 64'(if0.inst_pc), 64'h200);
        applyStimulus(0, 0, 0, '0);
        applyStimulus(0, 0, 0, '0);

        // Reset pulse mid-stream with a read in flight
        applyStimulus(0, 0, 0, '0);
        rstn = 1'b0;
        exp_q.delete();
        push_range(14'h0, 5);
        #1;
        checkOutput("mreset_inst",    if0.inst, NOP);
        checkOutput("mreset_inst_pc", 64'(if0.inst_pc), 64'h0);
        applyStimulus(0, 0, 0, '0);
        rstn = 1'b1;
        #1;
        checkOutput("mreset_c30_inst",    if0.inst, NOP);
        checkOutput("mreset_c30_addr",    64'(if0.imem_addr), 64'h0);
        checkOutput("mreset_c30_imem_en", 64'(if0.imem_en), 64'h1);
        applyStimulus(0, 0, 0, '0);
        checkOutput("mreset_c31_inst",    if0.inst, NOP);
        applyStimulus(0, 0, 0, '0);
        checkOutput("mreset_c32_inst_pc", 64'(if0.inst_pc), 64'h0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, '0);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        checkOutput("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
